// File: rtl/frame_scheduler_pkg.sv
// Shared definitions for the frame scheduler: scan geometry, pixel format,
// FSM state encoding and the pixel RAM address layout.
package frame_scheduler_pkg;

    localparam int COLS       = 128;
    localparam int ROWS       = 64;
    localparam int COL_W      = $clog2(COLS);
    localparam int ROW_W      = $clog2(ROWS);
    localparam int RGB_W      = 12;
    localparam int ADDR_W     = 1 + COL_W + ROW_W;
    localparam int TO_CNT_W   = 8;
    localparam int TIMEOUT_DEF = 255;

    localparam logic [RGB_W-1:0] ERR_COLOR_DEF = 12'hF0F;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        ISSUE,
        WAIT,
        WRITE,
        NEXT,
        SWAP_WAIT
    } state_e;

    // Pixel RAM layout: bank select on top, then block column, then block row.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic             bank,
                                                     input logic [COL_W-1:0] col,
                                                     input logic [ROW_W-1:0] row);
        return {bank, col, row};
    endfunction

endpackage

// File: rtl/frame_scheduler_scan.sv
// Block scan position: column is the inner loop, row the outer; last_o flags
// the final block of the frame.
module block_scan_counter
    import frame_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             adv_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             last_o
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             col_last;
    logic             row_last;

    assign col_last = (col_q == COL_W'(COLS - 1));
    assign row_last = (row_q == ROW_W'(ROWS - 1));

    // NOTE: defaults first so every path assigns col_d/row_d; otherwise a latch is inferred.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (adv_i) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                row_d = row_last ? '0 : row_q + 1'b1;
            end
        end
    end

    // NOTE: non-blocking for all registered state so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = col_last && row_last;

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: walks every pixel block once per frame, requests a trace,
// writes the result into the back bank and swaps banks on the next vsync fall.
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int               TIMEOUT   = TIMEOUT_DEF,
    parameter logic [RGB_W-1:0] ERR_COLOR = ERR_COLOR_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_en,
    input  logic                vs,
    output logic                snap,
    output logic                trace_start,
    output logic [COL_W-1:0]    trace_col,
    output logic [ROW_W-1:0]    trace_row,
    input  logic                trace_done,
    input  logic [RGB_W-1:0]    trace_pixel,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [RGB_W-1:0]    wr_data,
    output logic                rd_bank,
    output logic                frame_done,
    output logic [TO_CNT_W-1:0] timeout_cnt
);

    localparam int               WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_e              state_q;
    logic                snap_q;
    logic                start_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [RGB_W-1:0]    wr_data_q;
    logic                rd_bank_q;
    logic                frame_done_q;
    logic [TO_CNT_W-1:0] timeout_cnt_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic                vs_q;

    logic [COL_W-1:0]    scan_col;
    logic [ROW_W-1:0]    scan_row;
    logic                scan_last;
    logic                vs_fall;
    logic [ADDR_W-1:0]   back_addr;

    // Position is cleared while SNAP and only moves in NEXT, so it stays
    // stable from trace_start through the write of the same block.
    block_scan_counter u_scan (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == SNAP),
        .adv_i  (state_q == NEXT),
        .col_o  (scan_col),
        .row_o  (scan_row),
        .last_o (scan_last)
    );

    assign vs_fall   = vs_q && !vs;
    assign back_addr = pixel_addr(~rd_bank_q, scan_col, scan_row);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            snap_q        <= 1'b0;
            start_q       <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rd_bank_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_cnt_q <= '0;
            wait_cnt_q    <= '0;
            vs_q          <= 1'b1;
        end else begin
            vs_q         <= vs;
            snap_q       <= 1'b0;
            start_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (frame_en) begin
                        state_q <= SNAP;
                        snap_q  <= 1'b1;
                    end
                end

                SNAP: begin
                    timeout_cnt_q <= '0;
                    start_q       <= 1'b1;
                    state_q       <= ISSUE;
                end

                ISSUE: begin
                    wait_cnt_q <= '0;
                    state_q    <= WAIT;
                end

                WAIT: begin
                    // A real answer wins over a timeout landing in the same cycle.
                    if (trace_done) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= back_addr;
                        wr_data_q <= trace_pixel;
                        state_q   <= WRITE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= back_addr;
                        wr_data_q <= ERR_COLOR;
                        state_q   <= WRITE;
                        if (timeout_cnt_q != '1) begin
                            timeout_cnt_q <= timeout_cnt_q + 1'b1;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end

                WRITE: begin
                    state_q <= NEXT;
                end

                NEXT: begin
                    if (scan_last) begin
                        state_q <= SWAP_WAIT;
                    end else begin
                        start_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end

                SWAP_WAIT: begin
                    if (vs_fall) begin
                        rd_bank_q    <= ~rd_bank_q;
                        frame_done_q <= 1'b1;
                        if (frame_en) begin
                            snap_q  <= 1'b1;
                            state_q <= SNAP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign snap        = snap_q;
    assign trace_start = start_q;
    assign trace_col   = scan_col;
    assign trace_row   = scan_row;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign rd_bank     = rd_bank_q;
    assign frame_done  = frame_done_q;
    assign timeout_cnt = timeout_cnt_q;

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles to wait for trace_done before substituting ERR_COLOR.
REQ-002 SHALL have parameter ERR_COLOR, default 12'hF0F: pixel written when a trace times out.
REQ-003 clk  input  1  single clock for all state.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 frame_en  input  1  level; 1 permits starting a new frame.
REQ-006 vs  input  1  VGA vertical sync (active-low), synchronous to clk.
REQ-007 snap  output  1  one-cycle pulse commanding object state latch for the frame.
REQ-008 trace_start  output  1  one-cycle pulse requesting one pixel block trace.
REQ-009 trace_col  output  7  block column under trace (0..127).
REQ-010 trace_row  output  6  block row under trace (0..63).
REQ-011 trace_done  input  1  one-cycle pulse; trace_pixel valid this cycle.
REQ-012 trace_pixel  input  12  RGB444 result.
REQ-013 wr_en  output  1  pixel RAM write strobe.
REQ-014 wr_addr  output  14  {back_bank, col, row}.
REQ-015 wr_data  output  12  pixel written.
REQ-016 rd_bank  output  1  bank VGA reads (front).
REQ-017 frame_done  output  1  one-cycle pulse on bank swap.
REQ-018 timeout_cnt  output  8  saturating count of timed-out traces this frame.

Function
REQ-019 FSM states SHALL be IDLE, SNAP, ISSUE, WAIT, WRITE, NEXT, SWAP_WAIT.
REQ-020 IDLE -> SNAP when frame_en=1; SNAP asserts snap 1 cycle, clears col/row/timeout_cnt, -> ISSUE.
REQ-021 ISSUE SHALL assert trace_start 1 cycle with current col/row held stable until WRITE completes, -> WAIT.
REQ-022 WAIT: trace_done=1 -> WRITE capturing trace_pixel; wait counter reaching TIMEOUT -> WRITE with ERR_COLOR, timeout_cnt+1 (saturate 255).
REQ-023 trace_done arriving in any state other than WAIT SHALL be ignored.
REQ-024 WRITE SHALL assert wr_en exactly 1 cycle, wr_addr={~rd_bank,col,row}, -> NEXT.
REQ-025 NEXT: col increments; col wrap 127->0 increments row; after col=127,row=63 -> SWAP_WAIT, else -> ISSUE (8192 writes per frame, col inner loop).
REQ-026 SWAP_WAIT: on vs falling edge (registered vs=1, current vs=0), rd_bank toggles and frame_done pulses same cycle, -> SNAP if frame_en=1 else IDLE.
REQ-027 vs edge detection SHALL run every cycle; edges outside SWAP_WAIT SHALL not toggle rd_bank.
REQ-028 frame_en deassert mid-frame SHALL NOT abort; frame completes and swaps, then IDLE.
REQ-029 Pipeline latency: trace_done to wr_en SHALL be exactly 1 cycle; wr_en to next trace_start 2 cycles.
REQ-030 Writes SHALL never target rd_bank.

Reset
REQ-031 On rst=0: state IDLE, col=0, row=0, rd_bank=0, wait counter 0, timeout_cnt=0, vs register=1, all pulse outputs 0, wr_addr=0, wr_data=0.
REQ-032 Reset mid-frame SHALL abandon the frame with no further writes; no partial swap.

Structure
REQ-033 Shared package SHALL hold state encoding, COLS=128, ROWS=64, ERR_COLOR default, RGB444 width.
REQ-034 Scan counter (col/row with wrap and last flag) SHALL be a sub-module block_scan_counter; rest inline.

Verification
REQ-035 frame_en=1, model answers trace_done 3 cycles after each start -> 8192 wr_en, addresses {1,col,row} in order, snap once, frame_done on first vs fall, rd_bank=1.
REQ-036 Model never answers for pixel (5,2) -> that write has wr_data=12'hF0F 256 cycles after start, timeout_cnt=1, scan continues.
REQ-037 vs falls while still tracing (row 10) -> no toggle; toggle on next fall after last write.
REQ-038 Spurious trace_done in IDLE and NEXT -> no wr_en, no state change.
REQ-039 rst low at pixel 4000 -> outputs reset values next cycle, rd_bank=0; restart begins at (0,0).
REQ-040 frame_en dropped at pixel 100 -> frame finishes, swaps, IDLE; no second snap.
